sprite_blit_writer: RTL and testbench
=====================================

Name: sprite_blit_writer

Overview:
- Copies one SPRITE_W x SPRITE_H sprite, stored as palette indices in a sprite RAM, into the full-screen palette-index framebuffer RAM at a requested top-left position (x_pos, y_pos).
- Skips transparent pixels and clips anything off-screen.
- It is the write-side counterpart of the per-fruit image readers: it places sprite indices into the framebuffer that the VGA path later reads through the colour palette.
- Sits between game logic (which issues start) and the framebuffer RAM write port.

Parameters:
- SPRITE_W, 50, sprite width in pixels.
- SPRITE_H, 50, sprite height in pixels.
- VIDEO_WIDTH, 640, framebuffer width.
- VIDEO_HEIGHT, 480, framebuffer height.
- SPR_ADDR_W, 13, sprite RAM address width ($clog2(SPRITE_W*SPRITE_H)+1).
- FB_ADDR_W, 20, framebuffer address width ($clog2(VIDEO_WIDTH*VIDEO_HEIGHT)+1).
- IDX_W, 9, palette index width ($clog2(256)+1).
- TRANSPARENT_INDEX, 0, palette index that is never written.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to blit; sampled only in IDLE.
- x_pos  in  10  sprite left column on screen; latched on accepted start.
- y_pos  in  9  sprite top row on screen; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the last write cycle.
- done  out  1  one-cycle pulse after the final write slot.
- spr_addr  out  SPR_ADDR_W  sprite RAM read address (registered).
- spr_data  in  IDX_W  sprite RAM read data; valid exactly one cycle after spr_addr.
- fb_addr  out  FB_ADDR_W  framebuffer write address (registered).
- fb_data  out  IDX_W  framebuffer write data (registered).
- fb_wen  out  1  framebuffer write enable (registered).

Behaviour:
- Reset:
  - State = IDLE.
  - busy, done, fb_wen = 0.
  - spr_addr, fb_addr, fb_data = 0.
  - Counters and pipeline valid bits cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1 at edge E0, latch x0 = x_pos and y0 = y_pos; set sx = sy = 0; go to RUN.
  - Cycle numbering: cycle 1 is the cycle after E0.
- RUN:
  - Each cycle, spr_addr = sx + SPRITE_W*sy.
  - sx increments; on sx = SPRITE_W-1, sx wraps to 0 and sy increments.
  - Raster order, one address per cycle.
  - After issuing address SPRITE_W*SPRITE_H-1 (cycle 2500 at defaults), go to DRAIN.
- DRAIN: holds 2 cycles to flush the pipeline, then goes to DONE.
- DONE: done = 1 and busy = 0 for one cycle, then IDLE.
- Pipeline:
  - Stage 1 registers sx, sy and a valid bit alongside the address.
  - In the stage-2 cycle, spr_data arrives; screen coords are sxs = x0+sx (11 bits) and sys = y0+sy (10 bits), with no truncation.
  - Write condition: valid && spr_data != TRANSPARENT_INDEX && sxs < VIDEO_WIDTH && sys < VIDEO_HEIGHT.
  - When the condition holds, the next cycle drives fb_wen = 1, fb_addr = sxs + VIDEO_WIDTH*sys, fb_data = spr_data.
  - Otherwise fb_wen = 0, and fb_addr/fb_data hold their previous values.
- Latency: address issued in cycle c → write presented in cycle c+2.
- Timing at defaults:
  - busy = 1 in cycles 1..2502.
  - Last write slot is cycle 2502.
  - done = 1 in cycle 2503.
  - busy = 0 again in cycle 2503.
- start while busy or in DONE: ignored; x0/y0 unchanged.
- start in the same cycle as reset: reset wins.
- Reset mid-operation: the next cycle shows IDLE with fb_wen = 0 and busy = 0; done is not pulsed; no further writes.
- Fully off-screen sprite (x_pos >= 640 or y_pos >= 480): full timing still runs, zero writes, done still pulses at cycle 2503.
- Partial clip: only on-screen pixels are written; columns never wrap into the next row.
- fb_wen never asserts outside busy cycles.

Test Plan:
- Sprite RAM model with spr[i] = (i%255)+1; start at (0,0) → exactly 2500 writes. The write for sx=3, sy=2 has fb_addr=1283 and fb_data=104. done=1 at cycle 2503.
- Same RAM but spr[i]=0 for all even i; start at (100,50) → exactly 1250 writes, all with odd i. The first write has fb_addr=100+640*50+1=32101 and data spr[1]=2.
- Clip: start at (620,470) → exactly 200 writes (20x10). Maximum fb_addr = 639+640*479 = 307199. No write has column < 620.
- Off-screen: start at (640,0) and again at (0,480) → 0 writes in each case; busy high for 2502 cycles; done pulses once.
- start re-asserted at cycle 500 with (300,300) during a blit at (0,0) → ignored; all writes use origin (0,0); exactly one done pulse.
- Reset asserted in cycle 100 of a blit → in cycle 101 fb_wen=0, busy=0, done=0. A new start afterwards completes normally with 2500 writes.

Source files
------------

// File: rtl/sprite_blit_writer.sv
// sprite_blit_writer: copies one SPRITE_W x SPRITE_H sprite of palette indices
// from the sprite RAM into the framebuffer RAM with its top-left corner at
// (x_pos, y_pos). Transparent pixels are skipped and off-screen pixels are
// clipped. The sprite RAM has a one-cycle registered read, so the design runs
// a two-stage pipeline: stage 1 issues the read address together with the
// sprite coordinates, and stage 2 sees the read data, decides whether to
// write, and registers the framebuffer write for the following cycle.
module sprite_blit_writer #(
    parameter int SPRITE_W          = 50,
    parameter int SPRITE_H          = 50,
    parameter int VIDEO_WIDTH       = 640,
    parameter int VIDEO_HEIGHT      = 480,
    parameter int SPR_ADDR_W        = 13,
    parameter int FB_ADDR_W         = 20,
    parameter int IDX_W             = 9,
    parameter int TRANSPARENT_INDEX = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [9:0]            x_pos,
    input  logic [8:0]            y_pos,
    output logic                  busy,
    output logic                  done,
    output logic [SPR_ADDR_W-1:0] spr_addr,
    input  logic [IDX_W-1:0]      spr_data,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic [IDX_W-1:0]      fb_data,
    output logic                  fb_wen
);

    localparam int CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [9:0]            x0_q, x0_d;
    logic [8:0]            y0_q, y0_d;
    // Stage 1: coordinates of the address currently on spr_addr
    logic [CXW-1:0]        sx_q, sx_d;
    logic [CYW-1:0]        sy_q, sy_d;
    logic                  v1_q, v1_d;
    logic [SPR_ADDR_W-1:0] spr_addr_q, spr_addr_d;
    // Stage 2: coordinates that go with the spr_data arriving this cycle
    logic [CXW-1:0]        sx2_q, sx2_d;
    logic [CYW-1:0]        sy2_q, sy2_d;
    logic                  v2_q, v2_d;
    logic                  drain_q, drain_d;
    logic [FB_ADDR_W-1:0]  fb_addr_q, fb_addr_d;
    logic [IDX_W-1:0]      fb_data_q, fb_data_d;
    logic                  fb_wen_q, fb_wen_d;

    // Screen coordinates are one bit wider than the origin so a sprite
    // hanging off the right/bottom edge never wraps back on screen.
    logic [10:0] sxs;
    logic [9:0]  sys;
    logic        on_screen;
    logic        opaque;

    assign sxs       = {1'b0, x0_q} + 11'(sx2_q);
    assign sys       = {1'b0, y0_q} + 10'(sy2_q);
    assign on_screen = (sxs < 11'(VIDEO_WIDTH)) && (sys < 10'(VIDEO_HEIGHT));
    assign opaque    = (spr_data != IDX_W'(TRANSPARENT_INDEX));

    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign spr_addr = spr_addr_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;
    assign fb_wen   = fb_wen_q;

    // Next-state, raster address generation and write decision
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        v1_d       = 1'b0;
        spr_addr_d = spr_addr_q;
        drain_d    = drain_q;
        sx2_d      = sx_q;
        sy2_d      = sy_q;
        v2_d       = v1_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        fb_wen_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d       = x_pos;
                    y0_d       = y_pos;
                    sx_d       = '0;
                    sy_d       = '0;
                    spr_addr_d = '0;
                    v1_d       = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if ((sx_q == CXW'(SPRITE_W - 1)) && (sy_q == CYW'(SPRITE_H - 1))) begin
                    // Last address has been issued; let the pipeline empty.
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    v1_d       = 1'b1;
                    spr_addr_d = spr_addr_q + SPR_ADDR_W'(1);
                    if (sx_q == CXW'(SPRITE_W - 1)) begin
                        sx_d = '0;
                        sy_d = sy_q + CYW'(1);
                    end else begin
                        sx_d = sx_q + CXW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (v2_q && opaque && on_screen) begin
            fb_wen_d  = 1'b1;
            fb_addr_d = FB_ADDR_W'(sxs) + FB_ADDR_W'(sys) * FB_ADDR_W'(VIDEO_WIDTH);
            fb_data_d = spr_data;
        end
    end

    // State, pipeline and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            v1_q       <= 1'b0;
            spr_addr_q <= '0;
            sx2_q      <= '0;
            sy2_q      <= '0;
            v2_q       <= 1'b0;
            drain_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            fb_wen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            v1_q       <= v1_d;
            spr_addr_q <= spr_addr_d;
            sx2_q      <= sx2_d;
            sy2_q      <= sy2_d;
            v2_q       <= v2_d;
            drain_q    <= drain_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            fb_wen_q   <= fb_wen_d;
        end
    end

endmodule

// File: tb/tb_sprite_blit_writer.sv
// Bench for sprite_blit_writer: a sprite RAM model with registered read, a
// table of directed blits with hand-computed expectations, a reference model
// that lists every expected framebuffer write from the sprite contents and
// origin, plus hand-written restart, reset and randomized sequences.
module tb_sprite_blit_writer;

    localparam int SW = 50;
    localparam int SH = 50;
    localparam int VW = 640;
    localparam int VH = 480;
    localparam int NPIX = SW * SH;
    localparam int LAST_BUSY = NPIX + 2;
    localparam int DONE_CYC  = NPIX + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  x_pos = '0;
    logic [8:0]  y_pos = '0;
    logic        busy;
    logic        done;
    logic [12:0] spr_addr;
    logic [8:0]  spr_data = '0;
    logic [19:0] fb_addr;
    logic [8:0]  fb_data;
    logic        fb_wen;

    sprite_blit_writer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .busy     (busy),
        .done     (done),
        .spr_addr (spr_addr),
        .spr_data (spr_data),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_wen   (fb_wen)
    );

    always #5 clk = ~clk;

    // Sprite RAM with one-cycle registered read
    logic [8:0] mem [0:NPIX-1];
    always @(posedge clk) begin
        if (int'(spr_addr) < NPIX) spr_data <= mem[int'(spr_addr)];
        else spr_data <= '0;
    end

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int mode;
        int exp_writes;
        int exp_first_addr;
        int exp_first_data;
        int exp_max_addr;
        int exp_min_col;
    } vec_t;

    wr_t  got_q[$];
    wr_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   busy_bad;
    int   done_cnt;
    int   done_cyc;
    int   r_wen, r_busy, r_done;
    vec_t vecs[5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // mode 0: (i%255)+1, mode 1: same but even indices transparent, mode 2: random
    task automatic set_mem(input int mode);
        for (int i = 0; i < NPIX; i++) begin
            if (mode == 2) mem[i] = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            else if (mode == 1 && (i % 2) == 0) mem[i] = 9'd0;
            else mem[i] = 9'((i % 255) + 1);
        end
    endtask

    // Every opaque on-screen pixel in raster order; pixel i is written in cycle i+3
    task automatic build_model(input int x, input int y, input int limit_cyc);
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            int cx;
            int cy;
            cx = x + (i % SW);
            cy = y + (i / SW);
            if (mem[i] != 9'd0 && cx < VW && cy < VH && (limit_cyc == 0 || i + 3 <= limit_cyc))
                exp_q.push_back('{i + 3, cx + VW * cy, int'(mem[i])});
        end
    endtask

    task automatic compare_stream(input string name);
        int bad;
        int first_bad;
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            if (got_q[k].cyc != exp_q[k].cyc || got_q[k].addr != exp_q[k].addr ||
                got_q[k].data != exp_q[k].data) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        if (got_q.size() != exp_q.size()) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            if (first_bad >= 0)
                $display("FAIL %s: %0d bad writes, first #%0d got cyc=%0d addr=%0d data=%0d expected cyc=%0d addr=%0d data=%0d",
                         name, bad, first_bad, got_q[first_bad].cyc, got_q[first_bad].addr, got_q[first_bad].data,
                         exp_q[first_bad].cyc, exp_q[first_bad].addr, exp_q[first_bad].data);
            else
                $display("FAIL %s: got %0d writes expected %0d", name, got_q.size(), exp_q.size());
        end
    endtask

    // One blit; samples on the falling edge of cycles 1..last_cyc
    task automatic run_blit(input int x, input int y, input int restart_cyc, input int rst_cyc, input int last_cyc);
        int exp_busy;
        got_q.delete();
        busy_bad = 0;
        done_cnt = 0;
        done_cyc = -1;
        r_wen = -1;
        r_busy = -1;
        r_done = -1;
        @(negedge clk);
        x_pos = 10'(x);
        y_pos = 9'(y);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            exp_busy = (cyc <= LAST_BUSY && (rst_cyc == 0 || cyc <= rst_cyc)) ? 1 : 0;
            if (busy !== 1'(exp_busy)) busy_bad++;
            if (fb_wen === 1'b1 && busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (fb_wen === 1'b1) got_q.push_back('{cyc, int'(fb_addr), int'(fb_data)});
            if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
                r_wen  = int'(fb_wen);
                r_busy = int'(busy);
                r_done = int'(done);
            end
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) begin
                x_pos = 10'd300;
                y_pos = 9'd300;
            end
            reset = (cyc == rst_cyc);
            @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_timing(input string name);
        chk({name, "_busy_window"}, busy_bad, 0);
        chk({name, "_done_count"}, done_cnt, 1);
        chk({name, "_done_cycle"}, done_cyc, DONE_CYC);
    endtask

    initial begin
        int first_addr, first_data, max_addr, min_col;
        int found;

        vecs[0] = '{0,   0,   0, 2500, 0,      1,  31409,  0};
        vecs[1] = '{100, 50,  1, 1250, 32101,  2,  63509,  101};
        vecs[2] = '{620, 470, 0, 200,  301420, 1,  307199, 620};
        vecs[3] = '{640, 0,   0, 0,    -1,     -1, -1,     -1};
        vecs[4] = '{0,   480, 0, 0,    -1,     -1, -1,     -1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_fb_wen", fb_wen, 0);
        chk("reset_spr_addr", spr_addr, 0);
        chk("reset_fb_addr", fb_addr, 0);
        chk("reset_fb_data", fb_data, 0);

        // start together with reset: reset wins
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        chk("start_with_reset_busy", busy, 0);
        @(negedge clk);
        chk("start_with_reset_busy2", busy, 0);

        // Directed table
        for (int v = 0; v < 5; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            set_mem(vecs[v].mode);
            build_model(vecs[v].x, vecs[v].y, 0);
            run_blit(vecs[v].x, vecs[v].y, 0, 0, DONE_CYC + 5);
            first_addr = -1;
            first_data = -1;
            max_addr = -1;
            min_col = -1;
            if (got_q.size() > 0) begin
                first_addr = got_q[0].addr;
                first_data = got_q[0].data;
                min_col = VW;
            end
            foreach (got_q[k]) begin
                if (got_q[k].addr > max_addr) max_addr = got_q[k].addr;
                if (got_q[k].addr % VW < min_col) min_col = got_q[k].addr % VW;
            end
            chk({nm, "_writes"}, got_q.size(), vecs[v].exp_writes);
            chk({nm, "_first_addr"}, first_addr, vecs[v].exp_first_addr);
            chk({nm, "_first_data"}, first_data, vecs[v].exp_first_data);
            chk({nm, "_max_addr"}, max_addr, vecs[v].exp_max_addr);
            chk({nm, "_min_col"}, min_col, vecs[v].exp_min_col);
            compare_stream({nm, "_stream"});
            check_timing(nm);
            if (v == 0) begin
                // pixel sx=3, sy=2 is sprite index 103, written in cycle 106
                found = 0;
                foreach (got_q[k]) begin
                    if (got_q[k].cyc == 106) begin
                        found = 1;
                        chk("vec0_px3_2_addr", got_q[k].addr, 1283);
                        chk("vec0_px3_2_data", got_q[k].data, 104);
                    end
                end
                chk("vec0_px3_2_present", found, 1);
            end
        end

        // start re-asserted mid-blit is ignored
        set_mem(0);
        build_model(0, 0, 0);
        run_blit(0, 0, 500, 0, DONE_CYC + 20);
        chk("restart_writes", got_q.size(), 2500);
        compare_stream("restart_stream");
        check_timing("restart");

        // Reset in cycle 100 of a blit
        set_mem(0);
        build_model(0, 0, 100);
        run_blit(0, 0, 0, 100, 130);
        chk("midreset_wen", r_wen, 0);
        chk("midreset_busy", r_busy, 0);
        chk("midreset_done", r_done, 0);
        chk("midreset_done_count", done_cnt, 0);
        chk("midreset_busy_window", busy_bad, 0);
        compare_stream("midreset_stream");
        build_model(0, 0, 0);
        run_blit(0, 0, 0, 0, DONE_CYC + 5);
        chk("after_reset_writes", got_q.size(), 2500);
        compare_stream("after_reset_stream");
        check_timing("after_reset");

        // Randomized positions and sprite contents against the model
        for (int r = 0; r < 4; r++) begin
            int rx, ry;
            string nm;
            nm = $sformatf("rand%0d", r);
            rx = $urandom_range(0, 700);
            ry = $urandom_range(0, 511);
            set_mem(2);
            build_model(rx, ry, 0);
            run_blit(rx, ry, 0, 0, DONE_CYC + 5);
            compare_stream({nm, "_stream"});
            check_timing(nm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
